bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised multi-digit BCD counter, the successor to the single-digit BCD counter. Counts up or down in decimal across `DIGITS` cascaded BCD digits, with clock enable, synchronous parallel load with BCD validity check, and a terminal-count output for chaining counters. Sits in the counter/timer path wherever decimal display values or decimal-modulus timing are needed.

## Interface

Parameters:
- `DIGITS`, default 4, number of BCD digits (1..8); counter modulus is 10^DIGITS.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous parallel load request.
- `load_val`  in  4*DIGITS  value to load; digit k at bits [4k+3:4k], digit 0 least significant.
- `count`  out  4*DIGITS  current value, same digit packing; every digit always 0..9.
- `tc`  out  1  terminal count, combinational: `en & ~load & (up ? all digits 9 : all digits 0)`.
- `load_err`  out  1  registered one-cycle pulse: last `load` was rejected.

## Operation

- Reset (`reset` low, asynchronous): `count` = 0, `load_err` = 0; held while low. Release is synchronous to the next rising edge; first count step occurs on the first edge with `reset` high and `en` high.
- Priority per edge: `load` > `en` > hold.
- Load: if every digit of `load_val` is 0..9, `count` <= `load_val`, `load_err` <= 0. If any digit is 10..15, `count` holds and `load_err` <= 1 for exactly one cycle. `en` is ignored in a load cycle, valid or not.
- Up count (`en`=1, `up`=1, `load`=0): digit 0 increments; a digit at 9 becomes 0 and carries into the next digit; carry chain ripples through all digits in one cycle. All digits 9 -> all 0 (wrap).
- Down count (`en`=1, `up`=0, `load`=0): digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit. All digits 0 -> all 9 (wrap).
- `up` may change any cycle; the step direction is that sampled on the same edge.
- `en`=0 and `load`=0: `count` holds, `load_err` <= 0.
- `tc` is high in the cycle before a wrap, so `tc` of one instance drives `en` of the next for cascading (both on the same `clk`).
- Digit values 10..15 are unreachable in `count`; no state is entered that contains them.

## Timing

- Single clock domain, all state updated on rising `clk`.
- `count` latency: 1 cycle from `en`/`load` sampled to new value visible.
- `load_err` asserted the cycle after a rejected load, cleared on the following edge unless another invalid load occurs.
- `tc` combinational from `count`, `en`, `up`, `load`; no registered delay.
- Critical path: carry/borrow ripple across `DIGITS` digits plus `tc` decode; `DIGITS`=8 must meet the block's target clock.

## Structure

- Shared package: `BCD_MAX` = 4'd9, `BCD_MIN` = 4'd0, digit width constant `BCD_W` = 4, and a function `bcd_valid(digit)` reused by other BCD blocks.
- Sub-module `bcd_digit`: one 4-bit digit register with `step_en`, `up`, `load`, `load_digit` inputs and `carry_out` (at 9 going up / at 0 going down, gated by `step_en`); top level generates `DIGITS` instances, chains `carry_out` -> next `step_en`, and performs the all-digit load validity check and `load_err` register.

## Test plan

- Reset mid-count: `DIGITS`=4, count at 0137, drop `reset` between edges -> `count` = 0000 immediately, holds while low; release, `en`=1, `up`=1 -> 0001 on the first edge.
- Up wrap: load 9998, `en`=1, `up`=1 -> 9999 with `tc`=1, next edge 0000 with `tc`=0; 0099 -> 0100 checks multi-digit carry.
- Down wrap: load 0001, `up`=0, `en`=1 -> 0000 with `tc`=1, next edge 9999; 1000 -> 0999 checks multi-digit borrow.
- Invalid load: count 0042, `load`=1, `load_val`=0x12A4 -> `count` stays 0042, `load_err`=1 for one cycle, then 0; `load_val`=0x0A00 also rejected.
- Priority/hold: `load`=1 and `en`=1 with `load_val`=0x0500 -> 0500 (no step); `en`=0 for 5 cycles -> value unchanged, `tc`=0.
- Cascade: two `DIGITS`=1 instances, first `tc` -> second `en`, run 25 up-steps from 00 -> concatenated value 25; direction flip to down for 26 steps -> 99.

Source files
------------

// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD constants and digit helpers used by the decimal counter/timer blocks.
package bcd_counter_n_pkg;

  localparam int               BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One BCD digit register: load, up/down step, and carry/borrow out for the next digit.
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (step_en) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = step_en & (up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit up/down BCD counter with validated parallel load and cascadable terminal count.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    tc,
  output logic                    load_err
);

  logic              load_ok;
  logic              digit_load;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] step_en;
  logic              load_err_q;
  logic              load_err_d;

  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!bcd_valid(load_val[BCD_W*k +: BCD_W])) load_ok = 1'b0;
    end
  end

  assign digit_load = load & load_ok;

  // A load cycle, accepted or rejected, never steps the counter.
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_lsd
        assign step_en[k] = en & ~load;
      end else begin : g_upper
        assign step_en[k] = carry[k-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .step_en    (step_en[k]),
        .up         (up),
        .load       (digit_load),
        .load_digit (load_val[BCD_W*k +: BCD_W]),
        .digit      (count[BCD_W*k +: BCD_W]),
        .carry_out  (carry[k])
      );
    end
  endgenerate

  // The top carry is exactly en & ~load & (all digits at the wrap boundary).
  assign tc = carry[DIGITS-1];

  assign load_err_d = load & ~load_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: reset, wrap, carry/borrow, load rejection, priority, cascade.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc, load_err;

  logic        c_en, c_up, c_load;
  logic [3:0]  c0_count, c1_count;
  logic        c0_tc, c1_tc, c0_err, c1_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .load_err(load_err)
  );

  bcd_counter_n #(.DIGITS(1)) c0 (
    .clk(clk), .reset(reset), .en(c_en), .up(c_up), .load(c_load),
    .load_val(4'h0), .count(c0_count), .tc(c0_tc), .load_err(c0_err)
  );

  bcd_counter_n #(.DIGITS(1)) c1 (
    .clk(clk), .reset(reset), .en(c0_tc), .up(c_up), .load(c_load),
    .load_val(4'h0), .count(c1_count), .tc(c1_tc), .load_err(c1_err)
  );

  task automatic drive(input logic e, input logic u, input logic l, input logic [15:0] lv);
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== 16'h0000 || load_err !== 1'b0) begin
      errors++; $display("FAIL reset_init: count=%h err=%b, want 0000/0", count, load_err);
    end
    @(negedge clk); reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h0137); tick();
    checks++;
    if (count !== 16'h0137) begin
      errors++; $display("FAIL reset_preload: count=%h want 0137", count);
    end
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL reset_async: count=%h want 0000", count);
    end
    tick();
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL reset_hold: count=%h want 0000", count);
    end
    @(negedge clk); reset = 1'b1;
    tick();
    checks++;
    if (count !== 16'h0001) begin
      errors++; $display("FAIL reset_release: count=%h want 0001", count);
    end
  endtask

  task automatic test_up_wrap();
    drive(1'b0, 1'b1, 1'b1, 16'h9998); tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h9999 || tc !== 1'b1) begin
      errors++; $display("FAIL up_tc: count=%h tc=%b, want 9999/1", count, tc);
    end
    tick();
    checks++;
    if (count !== 16'h0000 || tc !== 1'b0) begin
      errors++; $display("FAIL up_wrap: count=%h tc=%b, want 0000/0", count, tc);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0099); tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h0100) begin
      errors++; $display("FAIL up_carry: count=%h want 0100", count);
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b0, 1'b0, 1'b1, 16'h0001); tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h0000 || tc !== 1'b1) begin
      errors++; $display("FAIL down_tc: count=%h tc=%b, want 0000/1", count, tc);
    end
    tick();
    checks++;
    if (count !== 16'h9999 || tc !== 1'b0) begin
      errors++; $display("FAIL down_wrap: count=%h tc=%b, want 9999/0", count, tc);
    end
    drive(1'b0, 1'b0, 1'b1, 16'h1000); tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h0999) begin
      errors++; $display("FAIL down_borrow: count=%h want 0999", count);
    end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 1'b1, 1'b1, 16'h0042); tick();
    drive(1'b1, 1'b1, 1'b1, 16'h12A4); tick();
    checks++;
    if (count !== 16'h0042 || load_err !== 1'b1) begin
      errors++; $display("FAIL bad_load_a: count=%h err=%b, want 0042/1", count, load_err);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h0042 || load_err !== 1'b0) begin
      errors++; $display("FAIL bad_load_clear: count=%h err=%b, want 0042/0", count, load_err);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0A00); tick();
    checks++;
    if (count !== 16'h0042 || load_err !== 1'b1) begin
      errors++; $display("FAIL bad_load_b: count=%h err=%b, want 0042/1", count, load_err);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0007); tick();
    checks++;
    if (count !== 16'h0007 || load_err !== 1'b0) begin
      errors++; $display("FAIL good_after_bad: count=%h err=%b, want 0007/0", count, load_err);
    end
  endtask

  task automatic test_priority_hold();
    drive(1'b0, 1'b1, 1'b1, 16'h9999); tick();
    drive(1'b1, 1'b1, 1'b1, 16'h0500);
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("FAIL tc_during_load: tc=%b want 0", tc);
    end
    tick();
    checks++;
    if (count !== 16'h0500 || load_err !== 1'b0) begin
      errors++; $display("FAIL load_over_en: count=%h err=%b, want 0500/0", count, load_err);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== 16'h0500 || tc !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: count=%h tc=%b, want 0500/0", i, count, tc);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 16'h0000); tick();
    tick();
    checks++;
    if (count !== 16'h0502) begin
      errors++; $display("FAIL b2b_up: count=%h want 0502", count);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000); tick();
    checks++;
    if (count !== 16'h0501) begin
      errors++; $display("FAIL b2b_flip: count=%h want 0501", count);
    end
  endtask

  task automatic test_cascade();
    @(negedge clk);
    c_load = 1'b1; c_en = 1'b0; c_up = 1'b1;
    tick();
    @(negedge clk);
    c_load = 1'b0; c_en = 1'b1;
    repeat (24) tick();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c1_count, c0_count} !== 8'h25 || c1_tc !== 1'b0) begin
      errors++; $display("FAIL cascade_up: value=%h tc1=%b, want 25/0", {c1_count, c0_count}, c1_tc);
    end
    c_up = 1'b0;
    repeat (25) tick();
    @(posedge clk);
    @(negedge clk);
    c_en = 1'b0;
    #1;
    checks++;
    if ({c1_count, c0_count} !== 8'h99 || c0_err !== 1'b0 || c1_err !== 1'b0) begin
      errors++; $display("FAIL cascade_down: value=%h errs=%b%b, want 99/00", {c1_count, c0_count}, c0_err, c1_err);
    end
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    c_en = 1'b0; c_up = 1'b1; c_load = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_invalid_load();
    test_priority_hold();
    test_back_to_back();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
